cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus (CDB) between NUM_FU functional units.
//  Each FU owns a 1-entry holding slot, so it can drop a result and move on.
//  Round-robin arbitration picks one occupied slot per cycle.
//  The winner is registered onto cdb_data, which feeds the ROB and the reservation stations.
// PARAMETERS
//  NUM_FU   4  number of result producers (ALU, mult, load, store-address); >=2
//  IDX_W    $clog2(NUM_FU)  width of round-robin pointer (derived, do not override)
// PORTS
//  clock       in   1                    clock; all state updates on posedge
//  reset       in   1                    reset, synchronous, active-high
//  fu_valid    in   NUM_FU               FU i presents a result this cycle
//  fu_rob_tag  in   NUM_FU*ROB_TAG_LEN   ROB tag of FU i result (legal 1..ROB_SIZE)
//  fu_value    in   NUM_FU*XLEN          result value or store address of FU i
//  fu_ready    out  NUM_FU               slot i can accept this cycle
//  cdb_data    out  CDB_DATA             registered broadcast {valid, rob_tag, value}
//  slots_busy  out  IDX_W+1              count of occupied slots (registered)
// BEHAVIOUR
//  State: slot_valid[i], slot_tag[i], slot_val[i], rr_ptr, cdb_data reg, slots_busy.
//  Reset (sync): all slot_valid=0, rr_ptr=0, cdb_data all-zero (valid=0), slots_busy=0.
//  fu_ready forced 0 while reset is high.
//  fu_ready[i] = !reset && (!slot_valid[i] || grant[i]).
//    This is combinational and does not depend on fu_valid.
//  Accept: fu_valid[i] && fu_ready[i] at posedge writes slot i (valid=1, tag, value).
//  fu_valid[i] && !fu_ready[i]: the FU holds its result; nothing is captured or lost.
//  Grant (comb): scan slots starting at rr_ptr, wrapping modulo NUM_FU.
//    The first occupied slot wins; grant is one-hot or zero.
//  Posedge with a grant to slot w:
//    - cdb_data <= {1, slot_tag[w], slot_val[w]}
//    - slot_valid[w] cleared unless refilled the same cycle (refill wins)
//    - rr_ptr <= (w+1) mod NUM_FU
//  Posedge with no grant: cdb_data.valid <= 0, tag/value <= 0; rr_ptr unchanged.
//  Latency: accept in cycle N -> eligible in N+1 -> on cdb_data in cycle N+2 at the earliest.
//  Throughput: 1 broadcast per cycle total.
//    A lone FU sustains 1 result/cycle via grant-and-refill.
//  Fairness: a waiting slot is granted within NUM_FU cycles of becoming occupied.
//  Starvation is impossible.
//  slots_busy <= popcount of next-state slot_valid.
//  Width: tags and values pass through unmodified; no arithmetic on data.
//  Tag 0 with fu_valid is illegal. The bench asserts on it; RTL behaviour is unspecified.
//  Reset mid-operation: pending slots are discarded, not broadcast.
//    cdb_data.valid is 0 in the cycle after reset; the ROB is reset in the same cycle.
//  No flush/squash input: the ROB never squashes, so every accepted result is broadcast exactly once.
// TESTING
//  1 Single result: fu_valid[1]=1, tag=3, value=0xDEAD at cycle 0.
//    -> cdb_data={1,3,0xDEAD} in cycle 2 only; slots_busy 1 then 0.
//  2 Simultaneous: all 4 FUs valid in cycle 0, tags 1..4, rr_ptr=0.
//    -> CDB tags 1,2,3,4 in cycles 2..5; fu_ready low until each slot is granted.
//  3 Round-robin: after slot 2 wins, slots 0 and 3 are both pending.
//    -> slot 3 broadcasts before slot 0; rr_ptr ends at 1.
//  4 Back-pressure: slot 0 full and losing to slot 3 (rr_ptr=3).
//    -> fu_ready[0]=0; FU0 holds tag 2, which is accepted the cycle slot 0 is granted; no loss or duplicate.
//  5 Streaming: FU2 valid every cycle with tags 1,2,3,4,1 and the other FUs idle.
//    -> 5 consecutive CDB beats in order; fu_ready[2] stays 1.
//  6 Reset mid-op: 3 slots full, reset for 1 cycle.
//    -> cdb_data.valid=0, slots_busy=0, fu_ready=0 during reset; none of the old tags is ever broadcast.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of the common data bus between NUM_FU units,
// each unit owning a one-entry holding slot in front of the registered broadcast.
module cdb_arbiter #(
   parameter int NUM_FU = 4,
   parameter int ROB_TAG_LEN = 4,
   parameter int XLEN = 32,
   localparam int IDX_W = $clog2(NUM_FU),
   localparam int CDB_W = 1 + ROB_TAG_LEN + XLEN
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_FU-1:0]             fu_valid,
   input  logic [NUM_FU*ROB_TAG_LEN-1:0] fu_rob_tag,
   input  logic [NUM_FU*XLEN-1:0]        fu_value,
   output logic [NUM_FU-1:0]             fu_ready,
   output logic [CDB_W-1:0]              cdb_data,
   output logic [IDX_W:0]                slots_busy
);
   logic [NUM_FU-1:0]      slot_valid;
   logic [ROB_TAG_LEN-1:0] slot_tag [NUM_FU];
   logic [XLEN-1:0]        slot_val [NUM_FU];
   logic [IDX_W-1:0]       rr_ptr;
   logic [NUM_FU-1:0]      grant;
   logic [IDX_W-1:0]       win;
   logic [IDX_W-1:0]       idx;
   logic                   found;
   logic [NUM_FU-1:0]      accept;
   logic [NUM_FU-1:0]      valid_nxt;
   logic [IDX_W:0]         busy_nxt;

   always_comb begin
      grant = '0;
      win = '0;
      idx = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_FU);
         if (!found && slot_valid[idx]) begin
            found = 1'b1;
            grant[idx] = 1'b1;
            win = idx;
         end
      end
   end

   // A granted slot drains this edge, so it can take a refill in the same cycle.
   assign fu_ready = reset ? '0 : (~slot_valid | grant);
   assign accept = fu_valid & fu_ready;
   assign valid_nxt = (slot_valid & ~grant) | accept;

   always_comb begin
      busy_nxt = '0;
      for (int i = 0; i < NUM_FU; i++) busy_nxt = busy_nxt + (IDX_W+1)'(valid_nxt[i]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         slot_valid <= '0;
         rr_ptr <= '0;
         cdb_data <= '0;
         slots_busy <= '0;
      end else begin
         slot_valid <= valid_nxt;
         slots_busy <= busy_nxt;
         if (found) begin
            cdb_data <= {1'b1, slot_tag[win], slot_val[win]};
            rr_ptr <= (win == IDX_W'(NUM_FU-1)) ? '0 : win + 1'b1;
         end else begin
            cdb_data <= '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (accept[i]) begin
            slot_tag[i] <= fu_rob_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN];
            slot_val[i] <= fu_value[i*XLEN +: XLEN];
         end
      end
   end
endmodule
